// File: rtl/cond_pkg.sv
// Shared definitions for the conditional issue stage: ARM condition codes,
// NZCV bit positions, FSM states and the condition-pass table.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int N_B = 3;
    localparam int Z_B = 2;
    localparam int C_B = 1;
    localparam int V_B = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    function automatic logic cond_pass(input logic [3:0] nzcv, input logic [3:0] cond);
        logic n, z, c, v, pass;
        n = nzcv[N_B];
        z = nzcv[Z_B];
        c = nzcv[C_B];
        v = nzcv[V_B];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: does cond pass for the given NZCV.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] nzcv,
    input  logic [3:0] cond,
    output logic       out
);

    assign out = cond_pass(nzcv, cond);

endmodule

// File: rtl/cond_issue_ctrl.sv
// Single-entry conditional issue stage: holds an instruction until its flags
// are valid, then offers it to execute with an execute/annul decision.
//
// state | meaning
// EMPTY | no instruction held
// WAIT  | instruction held, flags or pending-count not yet safe
// ISSUE | instruction offered downstream, out_exec valid
module cond_issue_ctrl
    import cond_pkg::*;
#(
    parameter  int TAG_W    = 8,
    parameter  int MAX_PEND = 3,
    parameter  int STALL_W  = 16,
    localparam int PEND_W   = $clog2(MAX_PEND + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_cond,
    input  logic               in_setf,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_exec,
    output logic [TAG_W-1:0]   out_tag,
    input  logic               flag_we,
    input  logic [3:0]         flag_nzcv,
    input  logic               flush,
    output logic [3:0]         nzcv_q,
    output logic [PEND_W-1:0]  pend,
    output logic [STALL_W-1:0] stall_cyc,
    output logic               err
);

    state_t             st;
    logic [3:0]         e_cond;
    logic               e_setf;
    logic [TAG_W-1:0]   e_tag;
    logic               exec_pass;
    logic               hs;
    logic               cap;
    logic               inc;
    logic               dec;
    logic [PEND_W-1:0]  pend_next;
    logic [3:0]         nzcv_next;
    logic               cap_wait;
    logic               held_wait;

    cond_eval u_eval (
        .nzcv (nzcv_q),
        .cond (e_cond),
        .out  (exec_pass)
    );

    // Blocking decisions look at next-cycle PEND/NZCV so an entry leaves WAIT
    // exactly one cycle after the final flag write-back.
    function automatic logic must_wait(input logic [3:0] cond, input logic setf,
                                       input logic [PEND_W-1:0] p, input logic [3:0] f);
        logic unconditional;
        unconditional = (cond == COND_AL) || (cond == COND_NV);
        return (!unconditional && (p != '0)) ||
               (setf && cond_pass(f, cond) && (p == PEND_W'(MAX_PEND)));
    endfunction

    assign out_valid = (st == ISSUE) && !flush;
    assign out_exec  = out_valid && exec_pass;
    assign out_tag   = e_tag;
    assign hs        = out_valid && out_ready;
    assign in_ready  = !flush && ((st == EMPTY) || hs);
    assign cap       = in_valid && in_ready;

    assign inc       = hs && exec_pass && e_setf;
    assign dec       = flag_we && (pend != '0);
    assign pend_next = pend + PEND_W'(inc) - PEND_W'(dec);
    assign nzcv_next = flag_we ? flag_nzcv : nzcv_q;
    assign cap_wait  = must_wait(in_cond, in_setf, pend_next, nzcv_next);
    assign held_wait = must_wait(e_cond, e_setf, pend_next, nzcv_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= EMPTY;
            e_cond <= 4'h0;
            e_setf <= 1'b0;
            e_tag  <= '0;
        end else if (flush) begin
            st <= EMPTY;
        end else if (cap) begin
            e_cond <= in_cond;
            e_setf <= in_setf;
            e_tag  <= in_tag;
            st     <= cap_wait ? WAIT : ISSUE;
        end else begin
            case (st)
                WAIT:    if (!held_wait) st <= ISSUE;
                ISSUE:   if (hs) st <= EMPTY;
                default: st <= st;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q    <= 4'h0;
            pend      <= '0;
            err       <= 1'b0;
            stall_cyc <= '0;
        end else begin
            nzcv_q <= nzcv_next;
            pend   <= pend_next;
            if (flag_we && (pend == '0))
                err <= 1'b1;
            if ((st == WAIT) && (stall_cyc != '1))
                stall_cyc <= stall_cyc + 1'b1;
        end
    end

endmodule
